// File: rtl/lab_bist_pkg.sv
// Shared definitions for the lab BIST checker: FSM state encoding and
// reference truth tables for the standard 2-input lab circuits.
package lab_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } bist_state_t;

    // Bit i is the expected output for input vector i (MSB of the vector = input A).
    localparam logic [3:0] CIRCUIT1_TT = 4'b1000;  // AND
    localparam logic [3:0] CIRCUIT2_TT = 4'b0110;  // XOR
    localparam logic [3:0] CIRCUIT3_TT = 4'b1110;  // OR
    localparam logic [3:0] CIRCUIT4_TT = 4'b0111;  // NAND

endpackage

// File: rtl/bist_vec_counter.sv
// Vector index and per-vector settle counter; each vector is held for
// SETTLE+1 enabled edges, and the index stops at the last vector instead of wrapping.
module bist_vec_counter #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr,
    input  logic            en,
    output logic [N_IN-1:0] vec,
    output logic            sample,
    output logic            last
);

    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    logic [N_IN-1:0] vec_reg;
    logic [3:0]      cnt_reg;

    assign vec    = vec_reg;
    assign sample = (cnt_reg == SETTLE_C);
    assign last   = (vec_reg == LAST_VEC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec_reg <= '0;
            cnt_reg <= '0;
        end else if (clr) begin
            vec_reg <= '0;
            cnt_reg <= '0;
        end else if (en) begin
            if (!sample) begin
                cnt_reg <= cnt_reg + 4'd1;
            end else if (!last) begin
                vec_reg <= vec_reg + 1'b1;
                cnt_reg <= '0;
            end
        end
    end

endmodule

// File: rtl/lab_bist_checker.sv
// Exhaustive self-checker for a small combinational lab circuit: walks every
// input vector, compares the sampled response to EXPECTED and latches the result.
module lab_bist_checker
    import lab_bist_pkg::*;
#(
    parameter int                  N_IN     = 2,
    parameter logic [2**N_IN-1:0]  EXPECTED = CIRCUIT2_TT,
    parameter int                  SETTLE   = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail
);

    localparam int ERR_W = N_IN + 1;

    bist_state_t     state_reg;
    logic [N_IN-1:0] vec;
    logic            sample;
    logic            last;
    logic            clr;
    logic            en;
    logic            mismatch;
    logic [ERR_W-1:0] err_next;

    assign clr      = (state_reg == ST_IDLE) && start;
    assign en       = (state_reg == ST_APPLY);
    assign mismatch = (dut_out != EXPECTED[vec]);
    assign err_next = err_count + ERR_W'(mismatch);

    // The vector register is the drive register, so dut_in is glitch-free and
    // holds the last vector while idle.
    assign dut_in = vec;

    bist_vec_counter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_vec_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .en      (en),
        .vec     (vec),
        .sample  (sample),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            first_fail <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg  <= ST_APPLY;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        first_fail <= '0;
                    end
                end
                ST_APPLY: begin
                    if (sample) begin
                        err_count <= err_next;
                        if (mismatch && !fail_valid) begin
                            first_fail <= vec;
                            fail_valid <= 1'b1;
                        end
                        // pass uses err_next so the final vector's compare is included.
                        if (last) begin
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_next == '0);
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab_bist_checker.sv
// Bench for lab_bist_checker: four checker instances with different settle
// times and DUT models, driven by directed and random truth tables.
module tb_lab_bist_checker;

    localparam int         SETTLE_OF [4] = '{2, 0, 0, 1};
    localparam logic [3:0] EXP_OF    [4] = '{4'b0110, 4'b1111, 4'b0110, 4'b0110};

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start      [4];
    logic [1:0] dut_in     [4];
    logic       dut_o      [4];
    logic       busy       [4];
    logic       done       [4];
    logic       pass       [4];
    logic [2:0] err_count  [4];
    logic       fail_valid [4];
    logic [1:0] first_fail [4];
    logic [3:0] tt         [4];
    logic       dut_q2;
    logic       dut_q3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instances 0 and 1 see an ideal combinational DUT; 2 and 3 see one with a register in its path.
    assign dut_o[0] = tt[0][dut_in[0]];
    assign dut_o[1] = tt[1][dut_in[1]];
    assign dut_o[2] = dut_q2;
    assign dut_o[3] = dut_q3;

    always @(posedge clk) begin
        dut_q2 <= tt[2][dut_in[2]];
        dut_q3 <= tt[3][dut_in[3]];
    end

    lab_bist_checker u0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .dut_in(dut_in[0]), .dut_out(dut_o[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
        .fail_valid(fail_valid[0]), .first_fail(first_fail[0])
    );

    lab_bist_checker #(.EXPECTED(EXP_OF[1]), .SETTLE(SETTLE_OF[1])) u1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .dut_in(dut_in[1]), .dut_out(dut_o[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
        .fail_valid(fail_valid[1]), .first_fail(first_fail[1])
    );

    lab_bist_checker #(.EXPECTED(EXP_OF[2]), .SETTLE(SETTLE_OF[2])) u2 (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .dut_in(dut_in[2]), .dut_out(dut_o[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err_count[2]),
        .fail_valid(fail_valid[2]), .first_fail(first_fail[2])
    );

    lab_bist_checker #(.EXPECTED(EXP_OF[3]), .SETTLE(SETTLE_OF[3])) u3 (
        .clk(clk), .reset_n(reset_n), .start(start[3]), .dut_in(dut_in[3]), .dut_out(dut_o[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(err_count[3]),
        .fail_valid(fail_valid[3]), .first_fail(first_fail[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_values(input int u, input string tag);
        check({tag, " dut_in"},     32'(dut_in[u]),     32'd0);
        check({tag, " busy"},       32'(busy[u]),       32'd0);
        check({tag, " done"},       32'(done[u]),       32'd0);
        check({tag, " pass"},       32'(pass[u]),       32'd0);
        check({tag, " err_count"},  32'(err_count[u]),  32'd0);
        check({tag, " fail_valid"}, 32'(fail_valid[u]), 32'd0);
        check({tag, " first_fail"}, 32'(first_fail[u]), 32'd0);
    endtask

    // Reference model: seen[v] is the response the checker actually samples for vector v.
    // Expected results follow from comparing that table with EXPECTED bit by bit.
    task automatic run_check(input int u, input logic [3:0] seen, input string tag);
        int         s;
        int         lat;
        int         v_exp;
        bit         got;
        logic [2:0] e_err;
        logic [1:0] e_first;
        s       = SETTLE_OF[u];
        lat     = 4 * (s + 1);
        e_err   = 3'd0;
        e_first = 2'd0;
        got     = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (seen[k] !== EXP_OF[u][k]) begin
                e_err   = e_err + 3'd1;
                e_first = 2'(k);
            end
        end
        $display("run %s: inst=%0d seen=%b expected_tt=%b model_err=%0d model_first=%0d",
                 tag, u, seen, EXP_OF[u], e_err, e_first);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        check({tag, " busy@start"},    32'(busy[u]),      32'd1);
        check({tag, " dut_in@start"},  32'(dut_in[u]),    32'd0);
        check({tag, " err@start"},     32'(err_count[u]), 32'd0);
        for (int n = 1; n <= lat + 4; n++) begin
            @(negedge clk);
            v_exp = n / (s + 1);
            if (v_exp > 3) v_exp = 3;
            if (n <= lat) check({tag, " dut_in step"}, 32'(dut_in[u]), 32'(v_exp));
            if (done[u] === 1'b1) begin
                check({tag, " latency"}, 32'(n), 32'(lat));
                got = 1'b1;
                break;
            end
            if (n < lat) check({tag, " busy"}, 32'(busy[u]), 32'd1);
        end
        check({tag, " done seen"},  32'(got),           32'd1);
        check({tag, " err_count"},  32'(err_count[u]),  32'(e_err));
        check({tag, " fail_valid"}, 32'(fail_valid[u]), 32'(e_err != 3'd0));
        check({tag, " first_fail"}, 32'(first_fail[u]), 32'(e_first));
        check({tag, " pass"},       32'(pass[u]),       32'(e_err == 3'd0));
        check({tag, " busy@done"},  32'(busy[u]),       32'd0);
        @(negedge clk);
        check({tag, " done width"}, 32'(done[u]),       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         dcount;
        int         dat;
        logic [3:0] r;
        logic [3:0] seen;
        logic [1:0] p2;

        for (int u = 0; u < 4; u++) start[u] = 1'b0;
        tt[0] = 4'b0110;
        tt[1] = 4'b1111;
        tt[2] = 4'b0110;
        tt[3] = 4'b0110;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++) check_reset_values(u, "reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Directed truth tables on the default checker (EXPECTED = XOR, SETTLE = 2).
        tt[0] = 4'b0110;
        run_check(0, tt[0], "xor");
        tt[0] = 4'b1000;
        run_check(0, tt[0], "and");

        // Stuck-at DUTs, SETTLE = 0, EXPECTED = all ones.
        tt[1] = 4'b1111;
        run_check(1, tt[1], "stuck1");
        tt[1] = 4'b0000;
        run_check(1, tt[1], "stuck0");

        for (int i = 0; i < 5; i++) begin
            r     = 4'($urandom_range(0, 15));
            tt[0] = r;
            run_check(0, tt[0], "rand_s2");
            r     = 4'($urandom_range(0, 15));
            tt[1] = r;
            run_check(1, tt[1], "rand_s0");
        end

        // Reset in the middle of vector 2 of a failing run.
        tt[0] = 4'b1000;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun dut_in", 32'(dut_in[0]), 32'd2);
        check("midrun err", 32'(err_count[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_values(0, "async reset");
        @(negedge clk);
        reset_n = 1'b1;
        dcount = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done[0] === 1'b1) dcount++;
            check("post reset idle busy", 32'(busy[0]), 32'd0);
        end
        check("post reset done count", 32'(dcount), 32'd0);
        tt[0] = 4'b0110;
        run_check(0, tt[0], "after_reset");

        // start re-asserted during a run must be ignored.
        tt[0] = 4'b0110;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        dcount = 0;
        dat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done[0] === 1'b1) begin
                dcount++;
                dat = n;
            end
            start[0] = (n == 3 || n == 7);
        end
        start[0] = 1'b0;
        $display("run ignore_start: done pulses=%0d at edge %0d", dcount, dat);
        check("ignore start done count", 32'(dcount), 32'd1);
        check("ignore start done edge", 32'(dat), 32'd12);
        check("ignore start pass", 32'(pass[0]), 32'd1);
        check("ignore start idle", 32'(busy[0]), 32'd0);

        // start held high: back-to-back runs with one idle cycle between.
        tt[0] = 4'b1000;
        start[0] = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 12) begin
                check("held run1 done", 32'(done[0]), 32'd1);
                check("held run1 err", 32'(err_count[0]), 32'd3);
            end
            if (n == 13) begin
                check("held idle busy", 32'(busy[0]), 32'd0);
                check("held idle done", 32'(done[0]), 32'd0);
            end
            if (n == 14) begin
                check("held restart busy", 32'(busy[0]), 32'd1);
                check("held restart err cleared", 32'(err_count[0]), 32'd0);
                start[0] = 1'b0;
            end
            if (n == 26) begin
                check("held run2 done", 32'(done[0]), 32'd1);
                check("held run2 err", 32'(err_count[0]), 32'd3);
                check("held run2 first", 32'(first_fail[0]), 32'd1);
                check("held run2 pass", 32'(pass[0]), 32'd0);
            end
        end
        $display("run held_start: two back-to-back runs complete");
        check("held final busy", 32'(busy[0]), 32'd0);

        // One-cycle-late DUT, SETTLE = 0: vector v samples the response to v-1;
        // vector 0 samples the response to the input held before the run.
        p2 = 2'd0;
        tt[2] = 4'b0110;
        seen = {tt[2][2:0], tt[2][p2]};
        run_check(2, seen, "delayed_s0");
        p2 = 2'd3;
        for (int i = 0; i < 4; i++) begin
            r     = 4'($urandom_range(0, 15));
            tt[2] = r;
            seen  = {tt[2][2:0], tt[2][p2]};
            run_check(2, seen, "delayed_rand");
        end

        // Same late DUT, SETTLE = 1: the register has caught up before sampling.
        tt[3] = 4'b0110;
        run_check(3, tt[3], "delayed_s1");
        r     = 4'($urandom_range(0, 15));
        tt[3] = r;
        run_check(3, tt[3], "delayed_s1_rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
